// File: rtl/mod_n_down_timer.sv
// Loadable mod-n down-counting timer with terminal-count pulse, one-shot or periodic reload.
// Optional feature macro: TIMER_PRESCALER_EN (internal tick every PRESCALE cycles instead of the tick port).
module mod_n_down_timer #(
   parameter int n        = 7,
   parameter int PRESCALE = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [n-1:0] load_data,
   input  logic         start,
   input  logic         stop,
   input  logic         tick,
   input  logic         auto_reload,
   output logic [n-1:0] count,
   output logic         busy,
   output logic         done,
   output logic         expired
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam logic [n-1:0] CNT_ONE = 1;

   state_t         state_q, state_d;
   logic [n-1:0]   count_q, count_d;
   logic [n-1:0]   reload_q, reload_d;
   logic           done_q, done_d;
   logic           busy_q, expired_q;
   logic           tick_int;

   generate
      if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
         $error("mod_n_down_timer: PRESCALE must be in 2..255");
      end
   endgenerate

`ifdef TIMER_PRESCALER_EN
   localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

   logic [7:0] pre_q, pre_d;

   assign tick_int = (state_q == ST_RUN) && (pre_q == PRE_LAST);

   // Restart the phase on any control event so a fresh run always waits a full PRESCALE.
   always_comb begin
      pre_d = pre_q + 8'd1;
      if (clear || load || start || (state_d != ST_RUN) || (pre_q == PRE_LAST)) begin
         pre_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick_int = tick;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (clear) begin
         count_d = '0;
         state_d = ST_IDLE;
      end else if (load) begin
         reload_d = load_data;
         count_d  = load_data;
         if (state_q == ST_EXPIRED) begin
            state_d = ST_IDLE;
         end
      end else if (stop) begin
         if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
         end
      end else if (start) begin
         if (state_q != ST_RUN) begin
            state_d = ST_RUN;
            if (state_q == ST_EXPIRED) begin
               count_d = reload_q;
            end
         end
      end else if (tick_int && (state_q == ST_RUN)) begin
         if (count_q != '0) begin
            count_d = count_q - CNT_ONE;
         end else begin
            done_d = 1'b1;
            if (auto_reload) begin
               count_d = reload_q;
            end else begin
               state_d = ST_EXPIRED;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         done_q    <= done_d;
         busy_q    <= (state_d == ST_RUN);
         expired_q <= (state_d == ST_EXPIRED);
      end
   end

   assign count   = count_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_mod_n_down_timer.sv
// Scoreboard bench for mod_n_down_timer (default build, external tick): directed plan plus random traffic.
module tb_mod_n_down_timer;

   localparam int N = 7;

   // Reference-model modes
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

   typedef struct packed {
      logic [N-1:0] count;
      logic         busy;
      logic         done;
      logic         expired;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0, clear = 1'b0, load = 1'b0;
   logic [N-1:0] load_data = '0;
   logic         start = 1'b0, stop = 1'b0, tick = 1'b0, auto_reload = 1'b0;
   logic [N-1:0] count;
   logic         busy, done, expired;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_txn = 0;

   int   m_mode = M_IDLE;
   int   m_count = 0;
   int   m_reload = 0;
   bit   m_done = 0;

   mod_n_down_timer #(.n(N), .PRESCALE(4)) dut (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_data(load_data),
      .start(start), .stop(stop), .tick(tick), .auto_reload(auto_reload),
      .count(count), .busy(busy), .done(done), .expired(expired)
   );

   always #5 clk = ~clk;

   // Behavioural model: one call per clock, highest-priority event wins.
   task automatic model_step(input bit r, c, l, input int d, input bit sa, sp, tk, ar);
      m_done = 0;
      if (r) begin
         m_mode = M_IDLE; m_count = 0; m_reload = 0;
         return;
      end
      if (c) begin
         m_count = 0; m_mode = M_IDLE;
         return;
      end
      if (l) begin
         m_reload = d; m_count = d;
         if (m_mode == M_EXPIRED) m_mode = M_IDLE;
         return;
      end
      if (sp) begin
         if (m_mode == M_RUN) m_mode = M_PAUSED;
         return;
      end
      if (sa) begin
         if (m_mode == M_EXPIRED) m_count = m_reload;
         m_mode = M_RUN;
         return;
      end
      if (tk && m_mode == M_RUN) begin
         if (m_count > 0) begin
            m_count = m_count - 1;
         end else begin
            m_done = 1;
            if (ar) m_count = m_reload;
            else    m_mode = M_EXPIRED;
         end
      end
   endtask

   // Drive one cycle of stimulus at the falling edge and queue the expected response.
   task automatic cyc(input bit r, c, l, input int d, input bit sa, sp, tk, ar);
      exp_t e;
      reset = r; clear = c; load = l; load_data = N'(d);
      start = sa; stop = sp; tick = tk; auto_reload = ar;
      model_step(r, c, l, d, sa, sp, tk, ar);
      e.count   = N'(m_count);
      e.busy    = (m_mode == M_RUN);
      e.done    = m_done;
      e.expired = (m_mode == M_EXPIRED);
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input bit ar);
      cyc(0, 0, 0, 0, 0, 0, 0, ar);
   endtask

   task automatic tk1(input bit ar);
      cyc(0, 0, 0, 0, 0, 0, 1, ar);
   endtask

   // Monitor: one expected entry per clock edge, checked just after the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_txn++;
         $display("txn %0d: count=%0d busy=%b done=%b expired=%b", n_txn, count, busy, done, expired);
         n_cmp += 4;
         if (count !== e.count) begin
            n_bad++;
            $display("FAIL txn %0d count: got %0d expected %0d", n_txn, count, e.count);
         end
         if (busy !== e.busy) begin
            n_bad++;
            $display("FAIL txn %0d busy: got %b expected %b", n_txn, busy, e.busy);
         end
         if (done !== e.done) begin
            n_bad++;
            $display("FAIL txn %0d done: got %b expected %b", n_txn, done, e.done);
         end
         if (expired !== e.expired) begin
            n_bad++;
            $display("FAIL txn %0d expired: got %b expected %b", n_txn, expired, e.expired);
         end
      end
   end

   initial begin
      @(negedge clk);

      // Reset for two cycles
      repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      idle(0);

      // One-shot from 5: six ticks to terminal count, then ticks ignored
      cyc(0, 0, 1, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         tk1(0);
         idle(0);
      end
      tk1(0);
      tk1(0);
      idle(0);

      // Periodic with reload 2: done once per three ticks
      cyc(0, 0, 1, 2, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         tk1(1);
         idle(1);
      end

      // Pause and resume
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 10, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      repeat (3) tk1(0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      repeat (4) tk1(0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      tk1(0);

      // Simultaneous events in RUN at count 4
      cyc(0, 0, 1, 4, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 1, 1, 9, 0, 0, 1, 0);
      cyc(0, 0, 1, 4, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 9, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1, 0, 0);
      idle(0);

      // Reload 0 periodic: done on every tick
      cyc(0, 0, 1, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      repeat (4) tk1(1);

      // Maximum reload value
      cyc(0, 0, 1, 127, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      repeat (3) tk1(0);

      // Randomised traffic
      for (int i = 0; i < 1000; i++) begin
         bit r, c, l, sa, sp, tk, ar;
         int d;
         r  = ($urandom_range(0, 199) == 0);
         c  = ($urandom_range(0, 49) == 0);
         l  = ($urandom_range(0, 19) == 0);
         sp = ($urandom_range(0, 24) == 0);
         sa = ($urandom_range(0, 9) == 0);
         tk = ($urandom_range(0, 1) == 1);
         ar = ($urandom_range(0, 2) != 0);
         d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 5));
         cyc(r, c, l, d, sa, sp, tk, ar);
      end
      idle(0);

      // Scoreboard must have drained within the bound
      @(posedge clk);
      #2;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mod_n_down_timer.md
Name: mod_n_down_timer

Overview:
Loadable mod-N down-counting timer. It is the count-down counterpart of the team's n_bit_counter up counter and is used for real-time timeouts and periodic events. A reload value is loaded, the timer decrements on qualified ticks, and it signals terminal count. It then either stops or reloads automatically.

Parameters:
n, 7, counter and reload-value width in bits
PRESCALE, 4, cycles per internal tick; used only when TIMER_PRESCALER_EN is defined; legal range 2..255

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  force count to 0, go IDLE, keep reload value
load  input  1  capture load_data into reload register and count
load_data  input  n  reload value
start  input  1  begin or resume counting
stop  input  1  pause counting
tick  input  1  decrement strobe; ignored when TIMER_PRESCALER_EN is defined
auto_reload  input  1  sampled at terminal count; 1 = periodic, 0 = one-shot
count  output  n  current count value
busy  output  1  high in RUN
done  output  1  one-cycle pulse at terminal count
expired  output  1  high in EXPIRED state

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: count=0, reload register=0, busy=0, done=0, expired=0, state=IDLE.
- States:
  - IDLE: not counting.
  - RUN: decrementing on ticks.
  - PAUSED: count frozen.
  - EXPIRED: one-shot has finished; count held at 0.
- Per-cycle priority: reset > clear > load > stop > start > tick.
- clear: count<=0, state<=IDLE. The reload register is unchanged.
- load:
  - reload<=load_data and count<=load_data.
  - From IDLE or EXPIRED, state<=IDLE.
  - From RUN or PAUSED, the state is unchanged, so counting continues from the new value.
  - A tick in the same cycle is ignored.
- stop: RUN->PAUSED. No effect in any other state.
- start:
  - IDLE, PAUSED or EXPIRED -> RUN.
  - From EXPIRED, count<=reload first.
  - Start while already in RUN has no effect.
  - A tick in the same cycle as start is ignored.
- tick in RUN:
  - If count!=0: count<=count-1.
  - If count==0 (terminal count): done=1 in the next cycle for exactly one cycle.
  - At terminal count with auto_reload=1: count<=reload, stay in RUN.
  - At terminal count with auto_reload=0: count stays 0, state<=EXPIRED.
- tick in IDLE, PAUSED or EXPIRED is ignored.
- Period is reload+1 ticks. With reload=0 and auto_reload=1, done pulses on every tick.
- Arithmetic is unsigned, width n. Count never underflows; 0 is handled only as terminal count.
- Maximum reload value is 2^n-1.
- busy = (state==RUN); expired = (state==EXPIRED). Both update on the same edge as the state change.
- Reset mid-count: all state is lost and no done pulse is produced.

Optional Feature:
TIMER_PRESCALER_EN
- Defined:
  - An internal prescaler counts 0..PRESCALE-1 while in RUN.
  - It produces an internal tick on the cycle the prescaler equals PRESCALE-1, then wraps to 0.
  - The prescaler resets to 0 on reset, clear, load, start, and on leaving RUN.
  - The tick port is ignored.
- Undefined: no prescaler logic exists and the external tick port drives decrements directly.

Test Plan:
1. reset=1 for 2 cycles -> count=0, busy=0, done=0, expired=0, state IDLE.
2. load_data=5, load; start; 6 ticks with auto_reload=0 -> count 5,4,3,2,1,0; done pulses one cycle after the 6th tick; expired=1; further ticks leave count=0.
3. load_data=2, auto_reload=1, start; 9 ticks -> count 2,1,0,2,1,0,...; done pulses exactly 3 times, one per 3 ticks; busy stays 1.
4. load 10, start, 3 ticks (count=7); stop; 4 ticks -> count stays 7, busy=0; start; 1 tick -> count=6.
5. Simultaneous events in RUN at count=4: clear+load+tick -> count=0, IDLE. load_data=9 with tick -> count=9, state RUN, no decrement. stop+start -> PAUSED.
6. With TIMER_PRESCALER_EN, PRESCALE=4: load 1, start, tick held low -> count=0 after 4 cycles; done one cycle after the 8th cycle; expired=1.
